i2c_cfg_sequencer: RTL and testbench

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

---
 rtl/cmos_cfg_pkg.sv | 23 ++
 rtl/cfg_delay_timer.sv | 51 +++++
 rtl/i2c_cfg_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cmos_cfg_pkg
// Shared definitions for the sensor configuration sequencer: default widths
// and the sequencer state encoding.
// -----------------------------------------------------------------------------
package cmos_cfg_pkg;

   localparam int DEF_REG_ADDR_W = 16;
   localparam int DEF_REG_DATA_W = 8;
   localparam int DEF_INDEX_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WRITE  = 3'd2,
      ST_READ   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DELAY  = 3'd5,
      ST_FINISH = 3'd6,
      ST_FAIL   = 3'd7
   } state_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// -----------------------------------------------------------------------------
// cfg_delay_timer
// Down-counter used for delay entries of the configuration table.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   i_load     in   load i_load_val and start counting
//   i_load_val in   number of cycles to wait (0 = expire right away)
//   o_expire   out  single-cycle pulse on the last cycle of the wait
// -----------------------------------------------------------------------------
module cfg_delay_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_active;
   logic             r_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         r_zero <= 1'b0;
         if (i_load) begin
            r_active <= (i_load_val != '0);
            r_zero   <= (i_load_val == '0);
         end else if (r_active && r_cnt == CNT_W'(1)) begin
            r_active <= 1'b0;
         end
      end
   end

   // Count value is pure data; only the active/zero flags need reset.
   always_ff @(posedge clk) begin
      if (i_load)
         r_cnt <= i_load_val;
      else if (r_active)
         r_cnt <= r_cnt - CNT_W'(1);
   end

   // Expire on the last counted cycle so a load of N spends N cycles waiting.
   assign o_expire = r_zero | (r_active && r_cnt == CNT_W'(1));

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cfg_sequencer
// Walks an external {addr, data} table and writes each entry to an image
// sensor through an I2C master, with optional read-back verify, per-entry
// retries and delay entries (addr == DELAY_ADDR, data = delay in units).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: begin a run (ignored while busy)
//   lut_index/lut_data    table address out, {addr, data} entry in
//   lut_size              number of valid table entries
//   i2c_req/rw/addr/wdata transaction request to the I2C master
//   i2c_done/nack/rdata   transaction completion from the I2C master
//   busy                  run in progress
//   cfg_done/cfg_err      sticky run outcome, err_index = failing entry
// -----------------------------------------------------------------------------
module i2c_cfg_sequencer
   import cmos_cfg_pkg::*;
#(
   parameter int                    REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int                    REG_DATA_W = DEF_REG_DATA_W,
   parameter int                    INDEX_W    = DEF_INDEX_W,
   parameter bit                    VERIFY_EN  = 1'b0,
   parameter int                    MAX_RETRY  = 3,
   parameter int                    DELAY_UNIT = 50000,
   parameter logic [REG_ADDR_W-1:0] DELAY_ADDR = '1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic [INDEX_W-1:0]               lut_index,
   input  logic [REG_ADDR_W+REG_DATA_W-1:0] lut_data,
   input  logic [INDEX_W:0]                 lut_size,
   output logic                             i2c_req,
   output logic                             i2c_rw,
   output logic [REG_ADDR_W-1:0]            i2c_addr,
   output logic [REG_DATA_W-1:0]            i2c_wdata,
   input  logic                             i2c_done,
   input  logic                             i2c_nack,
   input  logic [REG_DATA_W-1:0]            i2c_rdata,
   output logic                             busy,
   output logic                             cfg_done,
   output logic                             cfg_err,
   output logic [INDEX_W-1:0]               err_index
);

   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   // Wide enough for the largest data value times DELAY_UNIT.
   localparam int DLY_W   = REG_DATA_W + $clog2(DELAY_UNIT + 1);

   state_t                r_state, w_nxt_state;
   logic [INDEX_W-1:0]    r_idx, w_nxt_idx;
   logic [REG_ADDR_W-1:0] r_addr, w_nxt_addr;
   logic [REG_DATA_W-1:0] r_data, w_nxt_data;
   logic [REG_DATA_W-1:0] r_rdata, w_nxt_rdata;
   logic                  r_req, w_nxt_req;
   logic                  r_rw, w_nxt_rw;
   logic [RETRY_W-1:0]    r_retry, w_nxt_retry;
   logic                  r_done, w_nxt_done;
   logic                  r_err, w_nxt_err;
   logic [INDEX_W-1:0]    r_eidx, w_nxt_eidx;
   logic                  w_retry;
   logic                  w_load;
   logic                  w_expire;

   logic [REG_ADDR_W-1:0] w_lut_addr;
   logic [REG_DATA_W-1:0] w_lut_data;
   logic [DLY_W-1:0]      w_delay_val;

   assign w_lut_addr  = lut_data[REG_ADDR_W+REG_DATA_W-1 -: REG_ADDR_W];
   assign w_lut_data  = lut_data[REG_DATA_W-1:0];
   assign w_delay_val = DLY_W'(w_lut_data) * DLY_W'(DELAY_UNIT);

   cfg_delay_timer #(.CNT_W(DLY_W)) u_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_delay_val),
      .o_expire   (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_req   <= 1'b0;
         r_rw    <= 1'b0;
         r_retry <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_eidx  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_idx   <= w_nxt_idx;
         r_addr  <= w_nxt_addr;
         r_data  <= w_nxt_data;
         r_req   <= w_nxt_req;
         r_rw    <= w_nxt_rw;
         r_retry <= w_nxt_retry;
         r_done  <= w_nxt_done;
         r_err   <= w_nxt_err;
         r_eidx  <= w_nxt_eidx;
      end
   end

   always_ff @(posedge clk) begin
      r_rdata <= w_nxt_rdata;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_nxt_addr  = r_addr;
      w_nxt_data  = r_data;
      w_nxt_rdata = r_rdata;
      w_nxt_req   = r_req;
      w_nxt_rw    = r_rw;
      w_nxt_retry = r_retry;
      w_nxt_done  = r_done;
      w_nxt_err   = r_err;
      w_nxt_eidx  = r_eidx;
      w_retry     = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_nxt_done  = 1'b0;
               w_nxt_err   = 1'b0;
               w_nxt_idx   = '0;
               w_nxt_state = ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_nxt_retry = '0;
            if ({1'b0, r_idx} == lut_size) begin
               w_nxt_state = ST_FINISH;
            end else begin
               w_nxt_addr = w_lut_addr;
               w_nxt_data = w_lut_data;
               if (w_lut_addr == DELAY_ADDR) begin
                  w_load      = 1'b1;
                  w_nxt_state = ST_DELAY;
               end else begin
                  w_nxt_state = ST_WRITE;
               end
            end
         end
         // The first cycle of WRITE/READ sets up rw with req low, so every
         // attempt (including retries) shows the master a fresh req edge.
         ST_WRITE: begin
            if (!r_req) begin
               w_nxt_req = 1'b1;
               w_nxt_rw  = 1'b0;
            end else if (i2c_done) begin
               w_nxt_req = 1'b0;
               if (i2c_nack) begin
                  w_retry = 1'b1;
               end else if (VERIFY_EN) begin
                  w_nxt_state = ST_READ;
               end else begin
                  w_nxt_idx   = r_idx + INDEX_W'(1);
                  w_nxt_state = ST_FETCH;
               end
            end
         end
         ST_READ: begin
            if (!r_req) begin
               w_nxt_req = 1'b1;
               w_nxt_rw  = 1'b1;
            end else if (i2c_done) begin
               w_nxt_req   = 1'b0;
               w_nxt_rdata = i2c_rdata;
               if (i2c_nack)
                  w_retry = 1'b1;
               else
                  w_nxt_state = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (r_rdata == r_data) begin
               w_nxt_idx   = r_idx + INDEX_W'(1);
               w_nxt_state = ST_FETCH;
            end else begin
               w_retry = 1'b1;
            end
         end
         ST_DELAY: begin
            if (w_expire) begin
               w_nxt_idx   = r_idx + INDEX_W'(1);
               w_nxt_state = ST_FETCH;
            end
         end
         ST_FINISH: begin
            w_nxt_done  = 1'b1;
            w_nxt_state = ST_IDLE;
         end
         ST_FAIL: begin
            w_nxt_err   = 1'b1;
            w_nxt_state = ST_IDLE;
         end
         default: w_nxt_state = ST_IDLE;
      endcase
      if (w_retry) begin
         if (r_retry < RETRY_W'(MAX_RETRY)) begin
            w_nxt_retry = r_retry + RETRY_W'(1);
            w_nxt_state = ST_WRITE;
         end else begin
            w_nxt_eidx  = r_idx;
            w_nxt_state = ST_FAIL;
         end
      end
   end

   assign lut_index = r_idx;
   assign i2c_req   = r_req;
   assign i2c_rw    = r_rw;
   assign i2c_addr  = r_addr;
   assign i2c_wdata = r_data;
   assign busy      = (r_state != ST_IDLE);
   assign cfg_done  = r_done;
   assign cfg_err   = r_err;
   assign err_index = r_eidx;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_cfg_sequencer
// Two sequencer instances (verify off / verify on) share clock and reset.
// Each has a behavioural I2C slave that NACKs the first wnack writes and
// returns a corrupted value on the first rbad reads of every entry. A
// table-walk model predicts the transaction list and outcome of each run.
// -----------------------------------------------------------------------------
module tb_i2c_cfg_sequencer;

   localparam int MAXR = 3;
   localparam int DU   = 10;

   typedef struct packed {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start     [2];
   logic [7:0]  lut_index [2];
   logic [23:0] lut_data  [2];
   logic [8:0]  lut_size  [2];
   logic        i2c_req   [2];
   logic        i2c_rw    [2];
   logic [15:0] i2c_addr  [2];
   logic [7:0]  i2c_wdata [2];
   logic        i2c_done  [2];
   logic        i2c_nack  [2];
   logic [7:0]  i2c_rdata [2];
   logic        busy      [2];
   logic        cfg_done  [2];
   logic        cfg_err   [2];
   logic [7:0]  err_index [2];

   logic [15:0] lut_a [2][16];
   logic [7:0]  lut_d [2][16];
   int          wnack [2][16];
   int          rbad  [2][16];
   int          wcnt  [2][16];
   int          rcnt  [2][16];
   int          first_req [2];
   int          cyc = 0;

   txn_t obs_q[$];
   txn_t exp_q[$];
   bit   exp_err;
   int   exp_eidx;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2c_cfg_sequencer #(.REG_ADDR_W(16), .REG_DATA_W(8), .INDEX_W(8), .VERIFY_EN(1'b0),
                       .MAX_RETRY(MAXR), .DELAY_UNIT(DU)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .lut_index(lut_index[0]),
      .lut_data(lut_data[0]), .lut_size(lut_size[0]), .i2c_req(i2c_req[0]),
      .i2c_rw(i2c_rw[0]), .i2c_addr(i2c_addr[0]), .i2c_wdata(i2c_wdata[0]),
      .i2c_done(i2c_done[0]), .i2c_nack(i2c_nack[0]), .i2c_rdata(i2c_rdata[0]),
      .busy(busy[0]), .cfg_done(cfg_done[0]), .cfg_err(cfg_err[0]),
      .err_index(err_index[0]));

   i2c_cfg_sequencer #(.REG_ADDR_W(16), .REG_DATA_W(8), .INDEX_W(8), .VERIFY_EN(1'b1),
                       .MAX_RETRY(MAXR), .DELAY_UNIT(DU)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .lut_index(lut_index[1]),
      .lut_data(lut_data[1]), .lut_size(lut_size[1]), .i2c_req(i2c_req[1]),
      .i2c_rw(i2c_rw[1]), .i2c_addr(i2c_addr[1]), .i2c_wdata(i2c_wdata[1]),
      .i2c_done(i2c_done[1]), .i2c_nack(i2c_nack[1]), .i2c_rdata(i2c_rdata[1]),
      .busy(busy[1]), .cfg_done(cfg_done[1]), .cfg_err(cfg_err[1]),
      .err_index(err_index[1]));

   for (genvar g = 0; g < 2; g++) begin : g_slave
      int wt;
      assign lut_data[g] = {lut_a[g][lut_index[g][3:0]], lut_d[g][lut_index[g][3:0]]};

      initial begin
         txn_t t;
         int   k;
         wt = 0;
         i2c_done[g]  = 1'b0;
         i2c_nack[g]  = 1'b0;
         i2c_rdata[g] = '0;
         forever begin
            @(negedge clk);
            i2c_done[g] = 1'b0;
            i2c_nack[g] = 1'b0;
            if (i2c_req[g] && rst_n) begin
               if (first_req[g] < 0) first_req[g] = cyc;
               if (wt == 0) wt = $urandom_range(1, 4);
               wt--;
               if (wt == 0) begin
                  k = 0;
                  for (int i = 15; i >= 0; i--)
                     if (lut_a[g][i] == i2c_addr[g]) k = i;
                  t.rw   = i2c_rw[g];
                  t.addr = i2c_addr[g];
                  t.data = i2c_rw[g] ? 8'h00 : i2c_wdata[g];
                  obs_q.push_back(t);
                  if (!i2c_rw[g]) begin
                     i2c_nack[g] = (wcnt[g][k] < wnack[g][k]);
                     wcnt[g][k]++;
                  end else begin
                     i2c_rdata[g] = (rcnt[g][k] < rbad[g][k]) ? (lut_d[g][k] ^ 8'h09) : lut_d[g][k];
                     rcnt[g][k]++;
                  end
                  i2c_done[g] = 1'b1;
               end
            end else begin
               wt = 0;
            end
         end
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_table(input int g);
      for (int k = 0; k < 16; k++) begin
         lut_a[g][k] = '0;
         lut_d[g][k] = '0;
         wnack[g][k] = 0;
         rbad[g][k]  = 0;
      end
      lut_size[g] = '0;
   endtask

   task automatic set_entry(input int g, input int k, input logic [15:0] a,
                            input logic [7:0] d, input int wn, input int rb);
      lut_a[g][k] = a;
      lut_d[g][k] = d;
      wnack[g][k] = wn;
      rbad[g][k]  = rb;
   endtask

   // Table walk: every non-delay entry gets up to MAXR+1 attempts; an attempt
   // is a write, plus a read when verifying; it succeeds once the write is
   // ACKed and (if verifying) the readback matches.
   task automatic build_exp(input int g, input bit verify);
      int   wk, rk;
      bit   ok;
      txn_t t;
      exp_q.delete();
      exp_err  = 1'b0;
      exp_eidx = 0;
      for (int i = 0; i < int'(lut_size[g]); i++) begin
         if (lut_a[g][i] == 16'hFFFF) continue;
         wk = 0; rk = 0; ok = 1'b0;
         for (int a = 0; a <= MAXR && !ok; a++) begin
            t.rw = 1'b0; t.addr = lut_a[g][i]; t.data = lut_d[g][i];
            exp_q.push_back(t);
            wk++;
            if (wk <= wnack[g][i]) continue;
            if (!verify) begin ok = 1'b1; continue; end
            t.rw = 1'b1; t.data = 8'h00;
            exp_q.push_back(t);
            rk++;
            if (rk > rbad[g][i]) ok = 1'b1;
         end
         if (!ok) begin
            exp_err  = 1'b1;
            exp_eidx = i;
            return;
         end
      end
   endtask

   task automatic run(input int g, input bit restart, output int lat);
      int s;
      obs_q.delete();
      for (int k = 0; k < 16; k++) begin wcnt[g][k] = 0; rcnt[g][k] = 0; end
      first_req[g] = -1;
      @(negedge clk); start[g] = 1'b1; s = cyc;
      @(negedge clk); start[g] = 1'b0;
      for (int n = 0; n < 4000 && busy[g]; n++) begin
         @(negedge clk);
         start[g] = (restart && n == 8);
      end
      start[g] = 1'b0;
      if (busy[g]) chk_eq("run_timeout", 32'(busy[g]), 32'd0);
      lat = (first_req[g] < 0) ? -1 : first_req[g] - s;
   endtask

   task automatic compare(input int g, input string tag);
      chk_eq({tag, "_ntxn"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk_eq({tag, "_rw"}, 32'(obs_q[i].rw), 32'(exp_q[i].rw));
         chk_eq({tag, "_addr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
         if (!exp_q[i].rw) chk_eq({tag, "_wdata"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      end
      chk_eq({tag, "_done"}, 32'(cfg_done[g]), 32'(!exp_err));
      chk_eq({tag, "_err"}, 32'(cfg_err[g]), 32'(exp_err));
      chk_eq({tag, "_busy"}, 32'(busy[g]), 32'd0);
      if (exp_err) chk_eq({tag, "_eidx"}, 32'(err_index[g]), 32'(exp_eidx));
   endtask

   initial begin
      int lat0, lat1, nq, sz;
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         start[g] = 1'b0;
         first_req[g] = -1;
         clear_table(g);
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk_eq("rst_req", 32'(i2c_req[g]), 32'd0);
         chk_eq("rst_busy", 32'(busy[g]), 32'd0);
         chk_eq("rst_done", 32'(cfg_done[g]), 32'd0);
         chk_eq("rst_err", 32'(cfg_err[g]), 32'd0);
         chk_eq("rst_eidx", 32'(err_index[g]), 32'd0);
         chk_eq("rst_idx", 32'(lut_index[g]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Three plain writes, all ACKed.
      clear_table(0);
      set_entry(0, 0, 16'h3012, 8'hA1, 0, 0);
      set_entry(0, 1, 16'h3013, 8'h5B, 0, 0);
      set_entry(0, 2, 16'h0100, 8'h01, 0, 0);
      lut_size[0] = 9'd3;
      build_exp(0, 1'b0); run(0, 1'b0, lat0); compare(0, "three_wr");

      // Entry 1 NACKed twice, then ACKed.
      wnack[0][1] = 2;
      build_exp(0, 1'b0); run(0, 1'b1, lat1); compare(0, "nack2");

      // Entry 2 always NACKs: four attempts, then abort with no more requests.
      wnack[0][1] = 0; wnack[0][2] = 99;
      lut_size[0] = 9'd4;
      set_entry(0, 3, 16'h0200, 8'h77, 0, 0);
      build_exp(0, 1'b0); run(0, 1'b0, lat1); compare(0, "nack_all");
      nq = obs_q.size();
      repeat (20) @(negedge clk);
      chk_eq("post_fail_txn", 32'(obs_q.size()), 32'(nq));

      // Verify mode: first readback of entry 0 is 0x05 instead of 0x0C.
      clear_table(1);
      set_entry(1, 0, 16'h0010, 8'h0C, 0, 1);
      set_entry(1, 1, 16'h0020, 8'h33, 0, 0);
      lut_size[1] = 9'd2;
      build_exp(1, 1'b1); run(1, 1'b0, lat1); compare(1, "verify");

      // Delay entry of 2 units adds 2*DU cycles before the next request.
      clear_table(0);
      set_entry(0, 0, 16'h0100, 8'h11, 0, 0);
      lut_size[0] = 9'd1;
      build_exp(0, 1'b0); run(0, 1'b0, lat0); compare(0, "dly_base");
      set_entry(0, 0, 16'hFFFF, 8'h02, 0, 0);
      set_entry(0, 1, 16'h0100, 8'h11, 0, 0);
      lut_size[0] = 9'd2;
      build_exp(0, 1'b0); run(0, 1'b0, lat1); compare(0, "dly");
      chk_eq("dly_cycles_ok", 32'((lat1 - lat0) >= 2*DU - 1 && (lat1 - lat0) <= 2*DU + 1), 32'd1);

      // Empty table: done within three cycles, no requests.
      clear_table(0);
      obs_q.delete();
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      for (int n = 0; n < 2 && !cfg_done[0]; n++) @(negedge clk);
      chk_eq("empty_done", 32'(cfg_done[0]), 32'd1);
      repeat (4) @(negedge clk);
      chk_eq("empty_txn", 32'(obs_q.size()), 32'd0);

      // Reset while a write is outstanding, then replay from index 0.
      clear_table(0);
      set_entry(0, 0, 16'h0400, 8'hC3, 0, 0);
      set_entry(0, 1, 16'h0401, 8'h3C, 0, 0);
      lut_size[0] = 9'd2;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      for (int n = 0; n < 50 && !i2c_req[0]; n++) @(negedge clk);
      chk_eq("pre_rst_req", 32'(i2c_req[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_req", 32'(i2c_req[0]), 32'd0);
      chk_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk_eq("mid_rst_idx", 32'(lut_index[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_eq("post_rst_idle", 32'(busy[0]), 32'd0);
      build_exp(0, 1'b0); run(0, 1'b0, lat1); compare(0, "replay");

      // Randomised tables on both instances.
      for (int t = 0; t < 12; t++) begin
         int g;
         g = t % 2;
         clear_table(g);
         sz = $urandom_range(0, 6);
         for (int k = 0; k < sz; k++) begin
            if ($urandom_range(0, 5) == 0)
               set_entry(g, k, 16'hFFFF, 8'($urandom_range(0, 3)), 0, 0);
            else
               set_entry(g, k, {4'(k), 4'h0, 8'($urandom)}, 8'($urandom),
                         $urandom_range(0, 4), (g == 1) ? $urandom_range(0, 2) : 0);
         end
         lut_size[g] = 9'(sz);
         build_exp(g, g == 1);
         run(g, t[2], lat1);
         compare(g, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
